// File: rtl/mux_scan_receiver.sv
// mux_scan_receiver: scans an 8:1 complementary mux, one 8-bit frame per START; MUX_SCAN_RX_COMPL_CHECK_EN enables the Y0/Y1 fault check.
// Latency 8*(SETTLE+1) cycles START->VALID; no backpressure, START is ignored (not queued) while BUSY.
module mux_scan_receiver #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       Y0,
  input  logic       Y1,
  output logic       A1,
  output logic       A2,
  output logic       A4,
  output logic       EZ,
  output logic [7:0] Q,
  output logic       VALID,
  output logic       ERR,
  output logic       BUSY
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam state_t     SLOT_ENTRY  = (SETTLE > 0) ? S_SETTLE : S_SAMPLE;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] addr;
  logic [3:0] cnt;
  logic [7:0] cap;
  logic       last_slot;

  assign last_slot = (addr == 3'd7);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (START) state_nxt = SLOT_ENTRY;
      S_SETTLE: if (cnt == SETTLE_LAST) state_nxt = S_SAMPLE;
      S_SAMPLE: state_nxt = last_slot ? S_IDLE : SLOT_ENTRY;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Address only moves on the edge that samples it, so Y0/Y1 are read at a settled address.
  always_ff @(posedge CLK) begin
    if (RST) begin
      addr  <= 3'd0;
      cnt   <= 4'd0;
      cap   <= 8'h00;
      Q     <= 8'h00;
      VALID <= 1'b0;
    end else begin
      VALID <= 1'b0;
      unique case (state)
        S_IDLE: begin
          addr <= 3'd0;
          cnt  <= 4'd0;
        end
        S_SETTLE: begin
          cnt <= (cnt == SETTLE_LAST) ? 4'd0 : cnt + 4'd1;
        end
        S_SAMPLE: begin
          cap[addr] <= Y0;
          if (last_slot) begin
            Q     <= {Y0, cap[6:0]};
            VALID <= 1'b1;
            addr  <= 3'd0;
          end else begin
            addr <= addr + 3'd1;
          end
        end
        default: begin
          addr <= 3'd0;
          cnt  <= 4'd0;
        end
      endcase
    end
  end

`ifdef MUX_SCAN_RX_COMPL_CHECK_EN
  logic acc;
  logic slot_fault;

  // A healthy mux always drives Y1 = ~Y0; equality means a stuck or shorted line.
  assign slot_fault = (Y0 == Y1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      acc <= 1'b0;
      ERR <= 1'b0;
    end else if (state == S_IDLE) begin
      acc <= 1'b0;
    end else if (state == S_SAMPLE) begin
      acc <= acc | slot_fault;
      if (last_slot) begin
        ERR <= acc | slot_fault;
      end
    end
  end
`else
  logic unused_y1;

  assign unused_y1 = Y1;
  assign ERR       = 1'b0;
`endif

  assign A1   = addr[2];
  assign A2   = addr[1];
  assign A4   = addr[0];
  assign EZ   = (state == S_IDLE);
  assign BUSY = (state != S_IDLE);

endmodule

// File: tb/tb_mux_scan_receiver.sv
// Bench for mux_scan_receiver: two instances (SETTLE=0 and SETTLE=1) each driven by a behavioural 8:1 mux model.
// Expected frames go into a scoreboard queue when a scan is started and are popped when VALID pulses.
module tb_mux_scan_receiver;

`ifdef MUX_SCAN_RX_COMPL_CHECK_EN
  localparam logic FAULT_ERR = 1'b1;
`else
  localparam logic FAULT_ERR = 1'b0;
`endif

  localparam logic [14:0] RESET_STATUS = {1'b1, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0};

  logic       clk = 1'b0;
  logic       rst      [2];
  logic       start    [2];
  logic       fault_en [2];
  logic [7:0] x        [2];
  logic       y0       [2];
  logic       y1       [2];
  logic       a1       [2];
  logic       a2       [2];
  logic       a4       [2];
  logic       ez       [2];
  logic [7:0] q        [2];
  logic       valid    [2];
  logic       err      [2];
  logic       busy     [2];
  logic [2:0] addr     [2];

  logic [8:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Behavioural mux: Y0 = X[addr], Y1 = ~Y0, optionally shorted at slot 3; disabled mux read as 0.
  for (genvar d = 0; d < 2; d++) begin : g_mux
    assign addr[d] = {a1[d], a2[d], a4[d]};
    assign y0[d]   = ez[d] ? 1'b0 : x[d][addr[d]];
    assign y1[d]   = ez[d] ? 1'b0 :
                     ((fault_en[d] && addr[d] == 3'd3) ? x[d][addr[d]] : ~x[d][addr[d]]);
  end

  mux_scan_receiver #(.SETTLE(0)) dut0 (
    .CLK(clk), .RST(rst[0]), .START(start[0]), .Y0(y0[0]), .Y1(y1[0]),
    .A1(a1[0]), .A2(a2[0]), .A4(a4[0]), .EZ(ez[0]), .Q(q[0]),
    .VALID(valid[0]), .ERR(err[0]), .BUSY(busy[0])
  );

  mux_scan_receiver #(.SETTLE(1)) dut1 (
    .CLK(clk), .RST(rst[1]), .START(start[1]), .Y0(y0[1]), .Y1(y1[1]),
    .A1(a1[1]), .A2(a2[1]), .A4(a4[1]), .EZ(ez[1]), .Q(q[1]),
    .VALID(valid[1]), .ERR(err[1]), .BUSY(busy[1])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [14:0] status(input int d);
    return {ez[d], addr[d], q[d], valid[d], err[d], busy[d]};
  endfunction

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; start[d] = 1'b0; fault_en[d] = 1'b0; x[d] = 8'h00;
    end
    tick(); tick();
    rst[0] = 1'b0; rst[1] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        n_checks++;
        if (status(d) !== RESET_STATUS) begin
          n_fail++;
          $display("FAIL reset_idle dut%0d cycle %0d: status=%h expected=%h", d, i, status(d), RESET_STATUS);
        end
      end
    end
  endtask

  // One START pulse; checks latency, frame, error flag and that VALID is a single cycle.
  task automatic do_scan(input int d, input logic [7:0] xv, input logic fe, input string name);
    int n;
    int s;
    logic [8:0] e;
    s = (d == 0) ? 0 : 1;
    x[d] = xv; fault_en[d] = fe;
    exp_q.push_back({fe ? FAULT_ERR : 1'b0, xv});
    start[d] = 1'b1;
    tick();
    start[d] = 1'b0;
    n = 0;
    while (valid[d] !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    n_checks++;
    if (n != 8 * (s + 1)) begin
      n_fail++;
      $display("FAIL %s_latency dut%0d: cycles=%0d expected=%0d", name, d, n, 8 * (s + 1));
    end
    e = exp_q.pop_front();
    n_checks++;
    if ({err[d], q[d]} !== e) begin
      n_fail++;
      $display("FAIL %s_frame dut%0d: err,q=%b,%h expected=%b,%h", name, d, err[d], q[d], e[8], e[7:0]);
    end
    n_checks++;
    if (ez[d] !== 1'b1 || busy[d] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_idle_at_valid dut%0d: ez=%b busy=%b expected ez=1 busy=0", name, d, ez[d], busy[d]);
    end
    tick();
    n_checks++;
    if (valid[d] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_valid_width dut%0d: valid=%b expected=0", name, d, valid[d]);
    end
    fault_en[d] = 1'b0;
  endtask

  task automatic test_settle1_scan();
    logic [8:0] e;
    x[1] = 8'hA5;
    exp_q.push_back({1'b0, 8'hA5});
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      for (int h = 0; h < 2; h++) begin
        n_checks++;
        if (addr[1] !== 3'(k) || ez[1] !== 1'b0 || busy[1] !== 1'b1 || valid[1] !== 1'b0) begin
          n_fail++;
          $display("FAIL settle1_slot%0d_%0d: addr=%0d ez=%b busy=%b valid=%b expected addr=%0d ez=0 busy=1 valid=0",
                   k, h, addr[1], ez[1], busy[1], valid[1], k);
        end
        tick();
      end
    end
    e = exp_q.pop_front();
    n_checks++;
    if (valid[1] !== 1'b1 || {err[1], q[1]} !== e || ez[1] !== 1'b1 || addr[1] !== 3'd0) begin
      n_fail++;
      $display("FAIL settle1_done: valid=%b err=%b q=%h ez=%b addr=%0d expected valid=1 err=%b q=%h ez=1 addr=0",
               valid[1], err[1], q[1], ez[1], addr[1], e[8], e[7:0]);
    end
    tick();
    n_checks++;
    if (valid[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL settle1_valid_width: valid=%b expected=0", valid[1]);
    end
  endtask

  task automatic test_start_held();
    int n_valid;
    int n;
    logic [8:0] e;
    n_valid = 0;
    x[0] = 8'h3C;
    start[0] = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (i % 9 == 1) exp_q.push_back({1'b0, 8'h3C});
      n_checks++;
      if (valid[0] !== (i % 9 == 0)) begin
        n_fail++;
        $display("FAIL held_valid cycle %0d: valid=%b expected=%b", i, valid[0], (i % 9 == 0));
      end
      if (valid[0] === 1'b1) begin
        n_valid++;
        e = exp_q.pop_front();
        n_checks++;
        if ({err[0], q[0]} !== e) begin
          n_fail++;
          $display("FAIL held_frame cycle %0d: err,q=%b,%h expected=%b,%h", i, err[0], q[0], e[8], e[7:0]);
        end
      end
    end
    start[0] = 1'b0;
    n_checks++;
    if (n_valid != 3) begin
      n_fail++;
      $display("FAIL held_pulse_count: pulses=%0d expected=3", n_valid);
    end
    n = 0;
    while (valid[0] !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    e = exp_q.pop_front();
    n_checks++;
    if (valid[0] !== 1'b1 || {err[0], q[0]} !== e || n != 6) begin
      n_fail++;
      $display("FAIL held_last_frame: valid=%b q=%h wait=%0d expected valid=1 q=%h wait=6", valid[0], q[0], n, e[7:0]);
    end
    tick();
    n_checks++;
    if (busy[0] !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL held_drain: busy=%b queued=%0d expected busy=0 queued=0", busy[0], exp_q.size());
    end
  endtask

  task automatic test_start_while_busy();
    int n_valid;
    logic [8:0] e;
    n_valid = 0;
    x[1] = 8'h5A;
    exp_q.push_back({1'b0, 8'h5A});
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      start[1] = (i == 3 || i == 10);
      tick();
      if (valid[1] === 1'b1) begin
        n_valid++;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = 9'h1FF;
        n_checks++;
        if ({err[1], q[1]} !== e || i != 16) begin
          n_fail++;
          $display("FAIL busy_frame cycle %0d: q=%h expected q=%h at cycle 16", i, q[1], e[7:0]);
        end
      end
    end
    start[1] = 1'b0;
    n_checks++;
    if (n_valid != 1 || busy[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_ignored: pulses=%0d busy=%b expected pulses=1 busy=0", n_valid, busy[1]);
    end
  endtask

  task automatic test_compl_check();
    do_scan(1, 8'hFF, 1'b1, "fault_s1");
    do_scan(1, 8'hFF, 1'b0, "clean_s1");
    do_scan(0, 8'hFF, 1'b1, "fault_s0");
    do_scan(0, 8'h81, 1'b0, "clean_s0");
  endtask

  task automatic test_reset_mid_scan();
    int n;
    do_scan(1, 8'hA5, 1'b0, "pre_reset");
    x[1] = 8'h00;
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    n = 0;
    while (addr[1] !== 3'd4 && n < 100) begin
      tick();
      n++;
    end
    n_checks++;
    if (addr[1] !== 3'd4 || busy[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_reach_slot4: addr=%0d busy=%b expected addr=4 busy=1", addr[1], busy[1]);
    end
    rst[1] = 1'b1;
    tick();
    n_checks++;
    if (status(1) !== RESET_STATUS) begin
      n_fail++;
      $display("FAIL midreset_outputs: status=%h expected=%h", status(1), RESET_STATUS);
    end
    rst[1] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if (valid[1] !== 1'b0 || busy[1] !== 1'b0 || q[1] !== 8'h00) begin
        n_fail++;
        $display("FAIL midreset_quiet cycle %0d: valid=%b busy=%b q=%h expected 0,0,00", i, valid[1], busy[1], q[1]);
      end
    end
    do_scan(1, 8'h00, 1'b0, "post_reset");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_settle1_scan();
    test_start_held();
    test_start_while_busy();
    test_compl_check();
    test_reset_mid_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_scan_receiver.md
# mux_scan_receiver

- Receiving end of the 8:1 complementary-output multiplexer bus.
- Drives the select lines A1/A2/A4 and the active-high disable EZ, scans all eight slots in turn, and samples the true/complement pair Y0/Y1.
- Assembles each scan into an 8-bit frame, published with a one-cycle valid strobe.
- Sits between the multiplexer and downstream logic that consumes whole frames.

## Interface
- SETTLE, default 1: extra cycles an address is held before sampling; legal range 0..15.
- CLK  in  1  system clock; all state changes on rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  request one scan; sampled only in IDLE.
- Y0  in  1  mux true output.
- Y1  in  1  mux complement output.
- A1  out  1  select MSB (address = {A1,A2,A4}).
- A2  out  1  select middle bit.
- A4  out  1  select LSB.
- EZ  out  1  mux disable; 1 = mux outputs high-Z.
- Q  out  8  last completed frame; Q[k] = Y0 sampled at address k.
- VALID  out  1  one-cycle pulse: Q/ERR just updated.
- ERR  out  1  complement fault seen in the last completed frame.
- BUSY  out  1  scan in progress.

## Operation
- Reset values: A1=A2=A4=0, EZ=1, Q=8'h00, VALID=0, ERR=0, BUSY=0; FSM in IDLE.
- States: IDLE, SETTLE, SAMPLE.
- IDLE: EZ=1, address 0, BUSY=0.
  - START=1 at an edge → EZ=0, BUSY=1, address 0, settle counter cleared.
  - Next state SETTLE if SETTLE>0, else SAMPLE.
- SETTLE: counts SETTLE cycles with address stable, then → SAMPLE.
- SAMPLE: at the edge ending this cycle:
  - capture buffer bit [address] <= Y0;
  - fault accumulator |= (Y0 == Y1).
  - Address < 7: address+1, → SETTLE (or SAMPLE if SETTLE=0).
  - Address = 7: Q <= capture buffer incl. this bit, ERR <= accumulator incl. this slot, VALID <= 1, EZ <= 1, BUSY <= 0, address <= 0, → IDLE.
- Accumulator cleared on scan start.
- Q and ERR hold the previous frame until a scan completes; partial frames are never visible.
- START while BUSY is ignored and not queued.
- START held high: a new scan begins on the edge after each VALID pulse, because IDLE lasts one cycle.
- Address increments 0→7 without wrap; it returns to 0 only on completion or reset.
- RST mid-scan: all outputs return to reset values on that edge; no VALID; the partial frame is discarded.
- Y0/Y1 sampled as-is; no synchronizer (the mux is in the same clock domain).

## Timing
- START edge = t0.
- Each slot holds its address for SETTLE+1 cycles.
- Slot k is sampled at edge t0 + (k+1)(SETTLE+1).
- Final sample at edge t0 + 8(SETTLE+1); VALID high for exactly the following cycle, with Q/ERR already updated.
- Scan period with START held high: 8(SETTLE+1)+1 cycles.
- EZ low from t0 through the final sample edge; high the cycle VALID is high.
- Address changes only on edges; it is never changed in the same cycle it is sampled.

## Configuration
- MUX_SCAN_RX_COMPL_CHECK_EN defined: complement check active as described; ERR reports any slot with Y0 == Y1.
- Not defined: Y1 ignored, the accumulator is removed, and ERR is constant 0. All other behaviour and timing are identical.

## Test plan
- Reset → EZ=1, {A1,A2,A4}=000, Q=8'h00, VALID=0, ERR=0, BUSY=0; remains so with START=0 for 20 cycles.
- SETTLE=1, behavioural mux model with X=8'hA5, one START pulse:
  - addresses 0..7 each held 2 cycles;
  - VALID high in the cycle after edge t0+16;
  - Q=8'hA5, ERR=0, EZ back to 1.
- SETTLE=0, X=8'h3C, START held high for 30 cycles:
  - VALID pulses every 9 cycles, each with Q=8'h3C;
  - extra START during BUSY has no effect.
- Macro defined, force Y1=Y0 during slot 3, X=8'hFF:
  - Q=8'hFF, ERR=1 with VALID;
  - next clean scan ERR=0.
  - Macro undefined, same stimulus: ERR=0.
- After a frame Q=8'hA5, start a new scan with X=8'h00 and assert RST during slot 4:
  - next cycle all outputs at reset values (Q=8'h00), no VALID;
  - a following START completes normally with Q=8'h00.
